booth_mult8: RTL and testbench
==============================

# booth_mult8

Sequential 8x8 signed (two's-complement) multiplier using radix-2 Booth recoding. It sits directly upstream and downstream of the datapath's shared 8-bit combinational add/subtract unit. Each cycle it drives that unit's two operands and its subtract select, then captures the 8-bit sum back into its partial-product register. A full 16-bit product is ready after a fixed 16-cycle iteration.

## Interface
- No parameters; widths are fixed at 8-bit operands and a 16-bit product.
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new multiply; sampled only in IDLE.
- multiplicand  input  8  signed operand M; sampled when start is accepted.
- multiplier  input  8  signed operand Q; sampled when start is accepted.
- add_a  output  8  to adder in1; always equals the A register.
- add_b  output  8  to adder in2; always equals the M register.
- add_sub  output  1  to adder c_in; 1 = A-M, 0 = A+M; equals Q[0] & ~Qm1.
- add_sum  input  8  from adder out; combinational result of add_a ± add_b.
- product  output  16  signed result {A,Q}; registered, held until the next accepted start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; product is valid in the same cycle.

## Operation
- Registers: A[7:0], Q[7:0], Qm1, M[7:0], cnt[2:0], state, product[15:0], done, both_min.
- States are IDLE, ADD, SHIFT and DONE.
- IDLE:
  - On start=1, load A=0, Qm1=0, cnt=0, and go to ADD.
  - Operand swap: if multiplicand==8'h80 and multiplier!=8'h80, load M=multiplier and Q=multiplicand. Otherwise load M=multiplicand and Q=multiplier.
  - This keeps M≠-128 whenever possible, so the 8-bit A never overflows on A-M.
  - both_min is set when both operands equal 8'h80.
- ADD: if Q[0]^Qm1, A ← add_sum. If Q[0]==Qm1, A holds. Always go to SHIFT.
- SHIFT:
  - Arithmetic shift right of {A,Q,Qm1}: A[7] is replicated and Q[0] moves into Qm1.
  - cnt ← cnt+1.
  - If cnt==7 before the increment, go to DONE and load product from the shifted {A,Q}. If both_min, load 16'h4000 instead.
  - Otherwise return to ADD.
- DONE: done=1 for one cycle, then IDLE. busy=0 from DONE onward.
- Arithmetic is modulo-2^8 in the adder. The swap plus the both_min override makes product exact for all 65536 operand pairs.
- start is ignored while not in IDLE, including in the DONE cycle. Operand inputs are don't-care outside the accept cycle.

## Timing
- Reset values: state=IDLE, A=Q=M=0, Qm1=0, cnt=0, product=16'h0000, busy=0, done=0. Therefore add_a=0, add_b=0, add_sub=0.
- Accept: start is sampled high at edge E0 in IDLE. Iterations occupy edges E1..E16, alternating ADD then SHIFT. The state is DONE after E16, so done=1 and product is valid in the cycle E16–E17.
- The earliest next accept is edge E18: IDLE is entered at E17.
- Issue interval is 18 cycles per multiply when start is held high.
- The adder path is combinational inside the ADD cycle. add_sum must settle within one clk period of A/M/Q changing.
- rst mid-operation: at the next edge all registers return to reset values, including product=0. No done pulse is produced.
- rst and start high together: reset wins.

## Test plan
- Basic multiply: multiplicand=3, multiplier=5, start for 1 cycle.
  - done exactly 17 cycles after the accept edge, with product=16'h000F.
  - busy high for 16 cycles.
- Negative operand and overflow check: -7 × 6 gives product=16'hFFD6 (-42).
  - 127 × -128 gives 16'hC080 (-16256) with no swap.
  - -128 × 3 gives 16'hFE80 (-384) via the swap.
- Both minimum: -128 × -128 gives product=16'h4000. Also check 0 × -128 gives 16'h0000.
- Adder handshake: on every ADD cycle, check add_sub==Q[0]&~Qm1, add_a==A and add_b==M.
  - For 3×5, the ADD-cycle add_sub sequence is 1,0,1,0,0,0,0,0.
- Start ignored while busy: pulse start with new operands at cycles 5 and 16 after accept.
  - The first product is unchanged.
  - The next multiply starts only when start is high in IDLE.
- Mid-operation reset: assert rst at cycle 8 of a multiply.
  - Next cycle shows product=0, busy=0, done=0 and the IDLE state.
  - A following 2×2 yields 16'h0004.

Source files
------------

// File: rtl/booth_mult8.sv
// Sequential 8x8 signed radix-2 Booth multiplier driving an external shared
// 8-bit add/subtract unit; one ADD/SHIFT pair per multiplier bit.
module booth_mult8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic [7:0]  add_a,
  output logic [7:0]  add_b,
  output logic        add_sub,
  input  logic [7:0]  add_sum,
  output logic [15:0] product,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_a;
  logic [7:0]  r_q;
  logic        r_qm1;
  logic [7:0]  r_m;
  logic [2:0]  r_cnt;
  logic [15:0] r_product;
  logic        r_done;
  logic        r_both_min;

  logic        w_last;
  logic        w_swap;
  logic        w_both_min;

  assign w_last     = (r_cnt == 3'd7);
  // Keeping M away from -128 prevents A overflowing on A-M.
  assign w_swap     = (multiplicand == 8'h80) && (multiplier != 8'h80);
  assign w_both_min = (multiplicand == 8'h80) && (multiplier == 8'h80);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_ADD;
      S_ADD:   w_state_next = S_SHIFT;
      S_SHIFT: w_state_next = w_last ? S_DONE : S_ADD;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= 8'h00;
      r_q        <= 8'h00;
      r_qm1      <= 1'b0;
      r_m        <= 8'h00;
      r_cnt      <= 3'd0;
      r_product  <= 16'h0000;
      r_done     <= 1'b0;
      r_both_min <= 1'b0;
    end else begin
      r_done <= (r_state == S_SHIFT) && w_last;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a        <= 8'h00;
            r_qm1      <= 1'b0;
            r_cnt      <= 3'd0;
            r_both_min <= w_both_min;
            if (w_swap) begin
              r_m <= multiplier;
              r_q <= multiplicand;
            end else begin
              r_m <= multiplicand;
              r_q <= multiplier;
            end
          end
        end
        S_ADD: begin
          if (r_q[0] ^ r_qm1) r_a <= add_sum;
        end
        S_SHIFT: begin
          r_a   <= {r_a[7], r_a[7:1]};
          r_q   <= {r_a[0], r_q[7:1]};
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + 3'd1;
          if (w_last) begin
            // -128 * -128 = +16384 does not fit the 8-bit A path.
            r_product <= r_both_min ? 16'h4000 : {r_a[7], r_a, r_q[7:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign add_a   = r_a;
  assign add_b   = r_m;
  assign add_sub = r_q[0] & ~r_qm1;
  assign product = r_product;
  assign done    = r_done;
  assign busy    = (r_state == S_ADD) || (r_state == S_SHIFT);

endmodule

// File: tb/tb_booth_mult8.sv
// Bench for booth_mult8: arithmetic product/timing model checked every cycle,
// plus directed vectors with literal expectations.
module tb_booth_mult8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_sub;
  logic [7:0]  add_sum;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  booth_mult8 dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_sum(add_sum),
    .product(product), .busy(busy), .done(done)
  );

  // Shared combinational adder
  assign add_sum = add_sub ? (add_a - add_b) : (add_a + add_b);

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state: position within a multiply and the exact expected product.
  bit          m_busy = 0;
  bit          m_done = 0;
  int          m_k    = 0;
  logic [15:0] m_prod = 16'h0000;
  logic [15:0] m_exp  = 16'h0000;
  logic [7:0]  m_M    = 8'h00;
  logic [7:0]  m_Q    = 8'h00;
  int          m_pa, m_pb;
  bit          en = 0;
  logic [7:0]  cap_sub = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_prod = 16'h0000; m_M = 8'h00; m_Q = 8'h00;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      m_k++;
      if (m_k == 16) begin
        m_busy = 0; m_done = 1; m_prod = m_exp;
      end
    end else if (start) begin
      m_busy = 1; m_k = 0;
      if (multiplicand == 8'h80 && multiplier != 8'h80) begin
        m_M = multiplier; m_Q = multiplicand;
      end else begin
        m_M = multiplicand; m_Q = multiplier;
      end
      m_pa  = $signed(multiplicand);
      m_pb  = $signed(multiplier);
      m_exp = 16'(m_pa * m_pb);
    end
  end

  // A before iteration i = partial Booth sum of digits 0..i-1, scaled down by 2^i.
  function automatic logic [7:0] exp_a(input int i, input logic [7:0] M, input logic [7:0] Q);
    int p, mv, qm, qj;
    p  = 0;
    mv = $signed(M);
    for (int j = 0; j < i; j++) begin
      qm = (j == 0) ? 0 : int'(Q[j-1]);
      qj = int'(Q[j]);
      p += (qm - qj) * mv * (1 << j);
    end
    return 8'(p >>> i);
  endfunction

  always @(negedge clk) begin
    if (en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("product", product, m_prod);
      if (m_busy && (m_k % 2 == 0)) begin
        int i;
        i = m_k / 2;
        cap_sub[i] = add_sub;
        check("add_sub", add_sub, m_Q[i] & ~((i == 0) ? 1'b0 : m_Q[i-1]));
        check("add_b", add_b, m_M);
        check("add_a", add_a, exp_a(i, m_M, m_Q));
      end
    end
  end

  task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_p, input string name);
    int n, nb;
    n = 0; nb = 0;
    multiplicand = a; multiplier = b; start = 1'b1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (busy) nb++;
      if (done) break;
    end
    check({name, " latency"}, n, 17);
    check({name, " busy_cycles"}, nb, 16);
    check({name, " product"}, product, exp_p);
    $display("mul %0h x %0h -> %0h (expected %0h)", a, b, product, exp_p);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; multiplicand = 8'h00; multiplier = 8'h00;
    repeat (2) @(negedge clk);
    en = 1;
    check("reset product", product, 16'h0000);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset add_a", add_a, 0);
    check("reset add_b", add_b, 0);
    check("reset add_sub", add_sub, 0);
    rst = 1'b0;
    @(negedge clk);

    run_mul(8'd3, 8'd5, 16'h000F, "3x5");
    check("3x5 add_sub seq", cap_sub, 8'b0000_0101);
    run_mul(8'hF9, 8'd6, 16'hFFD6, "-7x6");
    run_mul(8'h7F, 8'h80, 16'hC080, "127x-128");
    run_mul(8'h80, 8'd3, 16'hFE80, "-128x3");
    run_mul(8'h80, 8'h80, 16'h4000, "-128x-128");
    run_mul(8'h00, 8'h80, 16'h0000, "0x-128");

    // start pulses while busy and in the done cycle are ignored
    multiplicand = 8'd10; multiplier = 8'hFD; start = 1'b1; n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      start = (n == 5 || n == 16 || n == 17);
      if (start) begin
        multiplicand = 8'd7; multiplier = 8'd7;
      end
      if (done) break;
    end
    check("ignore latency", n, 17);
    check("ignore product", product, 16'hFFE2);
    $display("mul a x fd with ignored starts -> %0h (expected ffe2)", product);
    @(negedge clk);
    start = 1'b0;
    check("ignore idle busy", busy, 0);
    @(negedge clk);
    check("ignore idle busy2", busy, 0);
    run_mul(8'd7, 8'd7, 16'h0031, "7x7");

    // reset at cycle 8 of a multiply, with start high alongside it
    multiplicand = 8'd5; multiplier = 8'd9; start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 7) begin
        rst = 1'b1; start = 1'b1;
      end
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("midrst product", product, 16'h0000);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst add_a", add_a, 0);
    check("midrst add_b", add_b, 0);
    check("midrst add_sub", add_sub, 0);
    $display("mid-operation reset -> product %0h busy %0b done %0b", product, busy, done);
    run_mul(8'd2, 8'd2, 16'h0004, "2x2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
